// File: rtl/egress_pkg.sv
// Shared types and constants for the egress pop arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package egress_pkg;

  typedef enum logic [1:0] {
    RESET  = 2'd0,
    INIT   = 2'd1,
    ACTIVE = 2'd2,
    ERROR  = 2'd3
  } state_t;

  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

  localparam int DEF_DATA_WIDTH   = 6;
  localparam int DEF_CREDIT_WIDTH = 3;
  localparam int DEF_MAX_CREDITS  = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester grant with last_grant history; ARB_FIXED_PRIO_EN selects fixed D0 priority.
// Latency: grant is combinational; last_grant updates on the clock after each grant.
// Backpressure: en low forces both grants low (caller folds in state and credit checks).
import egress_pkg::*;

module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: D0 always wins a tie, no history kept.
  always_comb begin
    gnt0 = en & req0;
    gnt1 = en & req1 & ~req0;
  end
`else
  logic last_grant;

  // Round-robin: on a tie, grant the requester that did not win last time.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && req1) begin
        if (last_grant == DEST_D1) gnt0 = 1'b1;
        else                       gnt1 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // History starts at D1 so that D0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset)     last_grant <= DEST_D1;
    else if (gnt0) last_grant <= DEST_D0;
    else if (gnt1) last_grant <= DEST_D1;
  end
`endif

endmodule

// File: rtl/egress_pop_arbiter.sv
// Pops D0/D1 under credit control and registers one tagged word per cycle onto the egress link.
// Latency: pop in cycle N -> FIFO data in N+1 -> data_out/valid_out/dest_out in N+2.
// Backpressure: credit based, no pop at zero credits or outside ACTIVE; ARB_FIXED_PRIO_EN picks fixed priority.
import egress_pkg::*;

module egress_pop_arbiter #(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CREDIT_WIDTH = DEF_CREDIT_WIDTH,
  parameter int MAX_CREDITS  = DEF_MAX_CREDITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [DATA_WIDTH-1:0]   data_in_D0,
  input  logic [DATA_WIDTH-1:0]   data_in_D1,
  input  logic                    empty_D0,
  input  logic                    empty_D1,
  input  logic                    credit_return,
  output logic                    D0_pop,
  output logic                    D1_pop,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out,
  output logic                    dest_out,
  output logic [CREDIT_WIDTH-1:0] credits,
  output logic                    idle_out,
  output logic                    active_out,
  output logic                    error_out
);

  localparam logic [CREDIT_WIDTH-1:0] MAX_CR = CREDIT_WIDTH'(MAX_CREDITS);

  state_t                  state_q, state_d;
  logic [CREDIT_WIDTH-1:0] credits_q;
  logic                    err_q;
  logic                    pend_vld_q;
  logic                    pend_dest_q;
  logic                    pop_en;
  logic                    pop_any;
  logic                    overflow;

  assign pop_en   = (state_q == ACTIVE) && (credits_q != '0);
  assign pop_any  = D0_pop | D1_pop;
  // A return with the counter already full and nothing consumed means the partner lied.
  assign overflow = (state_q == ACTIVE) && credit_return && !pop_any && (credits_q == MAX_CR);

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (pop_en),
    .req0  (~empty_D0),
    .req1  (~empty_D1),
    .gnt0  (D0_pop),
    .gnt1  (D1_pop)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RESET;
    else       state_q <= state_d;
  end

  // Next-state logic; ERROR is only left through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET:   state_d = INIT;
      INIT:    if (init) state_d = ACTIVE;
      ACTIVE:  if (overflow) state_d = ERROR;
      ERROR:   state_d = ERROR;
      default: state_d = RESET;
    endcase
  end

  // Credit counter: loaded on entering ACTIVE, moves only while ACTIVE, saturates at MAX_CR.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits_q <= '0;
    end else if (state_q == INIT && init) begin
      credits_q <= MAX_CR;
    end else if (state_q == ACTIVE) begin
      if (pop_any && !credit_return)
        credits_q <= credits_q - 1'b1;
      else if (!pop_any && credit_return && credits_q != MAX_CR)
        credits_q <= credits_q + 1'b1;
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset)         err_q <= 1'b0;
    else if (overflow) err_q <= 1'b1;
  end

  // Two-stage pipeline: remember the pop source, then capture the FIFO word a cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld_q  <= 1'b0;
      pend_dest_q <= DEST_D0;
      valid_out   <= 1'b0;
      dest_out    <= DEST_D0;
      data_out    <= '0;
    end else begin
      pend_vld_q  <= pop_any;
      pend_dest_q <= D1_pop ? DEST_D1 : DEST_D0;
      valid_out   <= pend_vld_q;
      if (pend_vld_q) begin
        dest_out <= pend_dest_q;
        data_out <= (pend_dest_q == DEST_D1) ? data_in_D1 : data_in_D0;
      end
    end
  end

  assign credits    = credits_q;
  assign error_out  = err_q;
  assign active_out = (state_q == ACTIVE);
  assign idle_out   = (state_q == ACTIVE) && empty_D0 && empty_D1 && !pend_vld_q;

endmodule

// File: tb/tb_egress_pop_arbiter.sv
// Directed checks of egress_pop_arbiter: table of per-cycle vectors plus corner sequences.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_egress_pop_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [5:0] data_in_D0;
  logic [5:0] data_in_D1;
  logic       empty_D0;
  logic       empty_D1;
  logic       credit_return;
  logic       D0_pop;
  logic       D1_pop;
  logic [5:0] data_out;
  logic       valid_out;
  logic       dest_out;
  logic [2:0] credits;
  logic       idle_out;
  logic       active_out;
  logic       error_out;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [5:0] W0 = 6'b010101;
  localparam logic [5:0] W1 = 6'b100011;

  egress_pop_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .data_in_D0    (data_in_D0),
    .data_in_D1    (data_in_D1),
    .empty_D0      (empty_D0),
    .empty_D1      (empty_D1),
    .credit_return (credit_return),
    .D0_pop        (D0_pop),
    .D1_pop        (D1_pop),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .dest_out      (dest_out),
    .credits       (credits),
    .idle_out      (idle_out),
    .active_out    (active_out),
    .error_out     (error_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, ini, e0, e1, cr;
    logic       p0, p1, v, d;
    logic [5:0] dat;
    logic [2:0] crd;
    logic       idl, act, err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, ini, e0, e1, cr, p0, p1, v, d,
                     input logic [5:0] dat, input logic [2:0] crd,
                     input logic idl, act, err);
    vec_t x;
    x.rst = rst; x.ini = ini; x.e0 = e0; x.e1 = e1; x.cr = cr;
    x.p0 = p0; x.p1 = p1; x.v = v; x.d = d; x.dat = dat; x.crd = crd;
    x.idl = idl; x.act = act; x.err = err;
    tbl.push_back(x);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Apply inputs just after the falling edge, then let combinational outputs settle.
  task automatic drive(input logic r, i, e0, e1, cr);
    @(negedge clk);
    reset = r; init = i; empty_D0 = e0; empty_D1 = e1; credit_return = cr;
    #1;
  endtask

  initial begin
    logic [1:0] g [3];
    reset = 1'b1; init = 1'b0; empty_D0 = 1'b1; empty_D1 = 1'b1;
    credit_return = 1'b0; data_in_D0 = W0; data_in_D1 = W1;
    @(negedge clk);

`ifndef ARB_FIXED_PRIO_EN
    //  rst ini e0 e1 cr | p0 p1 v d dat crd idl act err
    add(1,0,1,1,0, 0,0,0,0,0 ,0, 0,0,0);
    add(1,0,1,1,0, 0,0,0,0,0 ,0, 0,0,0);
    add(1,0,1,1,0, 0,0,0,0,0 ,0, 0,0,0);
    add(0,0,1,1,0, 0,0,0,0,0 ,0, 0,0,0);
    add(0,0,1,1,1, 0,0,0,0,0 ,0, 0,0,0);
    add(0,1,1,1,0, 0,0,0,0,0 ,0, 0,0,0);
    add(0,0,1,1,0, 0,0,0,0,0 ,4, 1,1,0);
    add(0,0,1,0,0, 0,1,0,0,0 ,4, 0,1,0);
    add(0,0,1,1,0, 0,0,0,0,0 ,3, 0,1,0);
    add(0,0,1,1,1, 0,0,1,1,W1,3, 1,1,0);
    add(0,0,1,1,0, 0,0,0,0,0 ,4, 1,1,0);
    add(0,0,0,0,1, 1,0,0,0,0 ,4, 0,1,0);
    add(0,0,0,0,1, 0,1,0,0,0 ,4, 0,1,0);
    add(0,0,0,0,1, 1,0,1,0,W0,4, 0,1,0);
    add(0,0,0,0,1, 0,1,1,1,W1,4, 0,1,0);
    add(0,0,0,0,1, 1,0,1,0,W0,4, 0,1,0);
    add(0,0,0,0,0, 0,1,1,1,W1,4, 0,1,0);
    add(0,0,0,0,0, 1,0,1,0,W0,3, 0,1,0);
    add(0,0,0,0,0, 0,1,1,1,W1,2, 0,1,0);
    add(0,0,0,0,0, 1,0,1,0,W0,1, 0,1,0);
    add(0,0,0,0,0, 0,0,1,1,W1,0, 0,1,0);
    add(0,0,0,0,0, 0,0,1,0,W0,0, 0,1,0);
    add(0,0,0,0,0, 0,0,0,0,0 ,0, 0,1,0);
    add(0,0,0,0,1, 0,0,0,0,0 ,0, 0,1,0);
    add(0,0,0,0,0, 0,1,0,0,0 ,1, 0,1,0);
    add(0,0,0,0,0, 0,0,0,0,0 ,0, 0,1,0);
    add(0,0,0,0,0, 0,0,1,1,W1,0, 0,1,0);
    add(0,0,1,1,1, 0,0,0,0,0 ,0, 1,1,0);
    add(0,0,1,1,1, 0,0,0,0,0 ,1, 1,1,0);
    add(0,0,1,1,1, 0,0,0,0,0 ,2, 1,1,0);
    add(0,0,1,1,1, 0,0,0,0,0 ,3, 1,1,0);
    add(0,0,1,1,1, 0,0,0,0,0 ,4, 1,1,0);
    add(0,0,0,0,0, 0,0,0,0,0 ,4, 0,0,1);
    add(0,0,0,0,1, 0,0,0,0,0 ,4, 0,0,1);
    add(1,0,0,0,0, 0,0,0,0,0 ,4, 0,0,1);
    add(0,0,1,1,0, 0,0,0,0,0 ,0, 0,0,0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ini, tbl[i].e0, tbl[i].e1, tbl[i].cr);
      chk("D0_pop",     i, {7'd0, D0_pop},     {7'd0, tbl[i].p0});
      chk("D1_pop",     i, {7'd0, D1_pop},     {7'd0, tbl[i].p1});
      chk("valid_out",  i, {7'd0, valid_out},  {7'd0, tbl[i].v});
      chk("credits",    i, {5'd0, credits},    {5'd0, tbl[i].crd});
      chk("idle_out",   i, {7'd0, idle_out},   {7'd0, tbl[i].idl});
      chk("active_out", i, {7'd0, active_out}, {7'd0, tbl[i].act});
      chk("error_out",  i, {7'd0, error_out},  {7'd0, tbl[i].err});
      if (tbl[i].v) begin
        chk("dest_out", i, {7'd0, dest_out}, {7'd0, tbl[i].d});
        chk("data_out", i, {2'd0, data_out}, {2'd0, tbl[i].dat});
      end
    end
`endif

    // Reset while a word is in flight: it must be dropped.
    drive(1,0,1,1,0);
    drive(0,0,1,1,0);
    drive(0,1,1,1,0);
    drive(0,0,0,1,0);
    chk("midrst_pop",     100, {7'd0, D0_pop},    8'd1);
    chk("midrst_credits", 100, {5'd0, credits},   8'd4);
    drive(1,0,0,1,0);
    drive(0,0,0,1,0);
    chk("midrst_valid",   101, {7'd0, valid_out}, 8'd0);
    chk("midrst_nopop",   101, {7'd0, D0_pop},    8'd0);
    chk("midrst_active",  101, {7'd0, active_out},8'd0);
    drive(0,0,0,1,0);
    chk("midrst_valid2",  102, {7'd0, valid_out}, 8'd0);

    // Tie-break order, then D0 drains and D1 is served.
`ifdef ARB_FIXED_PRIO_EN
    g[0] = 2'd0; g[1] = 2'd0; g[2] = 2'd0;
`else
    g[0] = 2'd0; g[1] = 2'd1; g[2] = 2'd0;
`endif
    drive(1,0,1,1,0);
    drive(0,0,1,1,0);
    drive(0,1,1,1,0);
    for (int k = 0; k < 3; k++) begin
      drive(0,0,0,0,1);
      chk("tie_D0_pop", 200 + k, {7'd0, D0_pop}, {7'd0, g[k] == 2'd0});
      chk("tie_D1_pop", 200 + k, {7'd0, D1_pop}, {7'd0, g[k] == 2'd1});
    end
    chk("tie_valid0", 203, {7'd0, valid_out}, 8'd1);
    chk("tie_dest0",  203, {7'd0, dest_out},  {6'd0, g[0]});
    drive(0,0,1,0,1);
    chk("drain_D1_pop", 204, {7'd0, D1_pop},   8'd1);
    chk("drain_D0_pop", 204, {7'd0, D0_pop},   8'd0);
    chk("tie_dest1",    204, {7'd0, dest_out}, {6'd0, g[1]});
    drive(0,0,1,1,0);
    chk("tie_dest2",    205, {7'd0, dest_out}, {6'd0, g[2]});
    chk("tie_data2",    205, {2'd0, data_out}, (g[2] == 2'd1) ? {2'd0, W1} : {2'd0, W0});
    drive(0,0,1,1,0);
    chk("drain_valid",  206, {7'd0, valid_out}, 8'd1);
    chk("drain_dest",   206, {7'd0, dest_out},  8'd1);
    chk("drain_data",   206, {2'd0, data_out},  {2'd0, W1});
    chk("drain_credits",206, {5'd0, credits},   8'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
